// File: rtl/bus_cycle_responder_if.sv
// Bus-cycle handshake between the CPU-side decoder (master) and the cycle responder (slave).
interface bus_cycle_responder_if;
    logic       as;
    logic [1:0] port_width;
    logic       device_null;
    logic       int_ack;
    logic       use_device_ack;
    logic       device_ack;
    logic [1:0] dsack;
    logic       berr;
    logic       avec;
    logic       cycle_active;

    modport master (
        output as, port_width, device_null, int_ack, use_device_ack, device_ack,
        input  dsack, berr, avec, cycle_active
    );

    modport slave (
        input  as, port_width, device_null, int_ack, use_device_ack, device_ack,
        output dsack, berr, avec, cycle_active
    );
endinterface

// File: rtl/bus_cycle_responder.sv
// Terminates CPU bus cycles: sized DSACK after programmable wait states or device ready,
// bus error on null decode or timeout, autovector on interrupt acknowledge.
module bus_cycle_responder #(
    parameter int unsigned WAIT_STATES  = 2,
    parameter int unsigned BERR_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bus_cycle_responder_if.slave bus
);

    localparam int unsigned WAIT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int unsigned TMO_W  = $clog2(BERR_TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_n;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_n;
    logic [1:0]        cap_width_q, cap_width_n;
    logic              cap_dev_ack_q, cap_dev_ack_n;
    logic [1:0]        dsack_q, dsack_n;
    logic              berr_q, berr_n;
    logic              avec_q, avec_n;
    logic              active_q, active_n;

    logic              ack_ok;
    logic              timeout_hit;

    // Timeout counter holds clocks elapsed since the start edge, so berr lands on edge N+BERR_TIMEOUT.
    always_comb begin
        ack_ok      = (wait_cnt_q == WAIT_W'(0)) && (!cap_dev_ack_q || bus.device_ack);
        timeout_hit = (tmo_cnt_q >= TMO_W'(BERR_TIMEOUT));
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n       = state_q;
        wait_cnt_n    = wait_cnt_q;
        tmo_cnt_n     = tmo_cnt_q;
        cap_width_n   = cap_width_q;
        cap_dev_ack_n = cap_dev_ack_q;
        dsack_n       = dsack_q;
        berr_n        = berr_q;
        avec_n        = avec_q;

        unique case (state_q)
            ST_IDLE: begin
                dsack_n = 2'b00;
                berr_n  = 1'b0;
                avec_n  = 1'b0;
                if (bus.as) begin
                    if (bus.int_ack) begin
                        avec_n  = 1'b1;
                        state_n = ST_HOLD;
                    end else if ((bus.port_width == 2'b00) || bus.device_null) begin
                        berr_n  = 1'b1;
                        state_n = ST_HOLD;
                    end else begin
                        wait_cnt_n    = WAIT_W'(WAIT_STATES);
                        tmo_cnt_n     = TMO_W'(1);
                        cap_width_n   = bus.port_width;
                        cap_dev_ack_n = bus.use_device_ack;
                        state_n       = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!bus.as) begin
                    // Aborted cycle: nothing has been driven yet, just fall back.
                    dsack_n = 2'b00;
                    berr_n  = 1'b0;
                    avec_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    if (wait_cnt_q != WAIT_W'(0)) begin
                        wait_cnt_n = wait_cnt_q - WAIT_W'(1);
                    end
                    if (!timeout_hit) begin
                        tmo_cnt_n = tmo_cnt_q + TMO_W'(1);
                    end
                    // Acknowledge has priority over a coincident timeout.
                    if (ack_ok) begin
                        dsack_n = cap_width_q;
                        state_n = ST_HOLD;
                    end else if (timeout_hit) begin
                        berr_n  = 1'b1;
                        state_n = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (!bus.as) begin
                    dsack_n = 2'b00;
                    berr_n  = 1'b0;
                    avec_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end

            default: begin
                dsack_n = 2'b00;
                berr_n  = 1'b0;
                avec_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        active_n = (state_n != ST_IDLE);
    end

    // State, counters, captured attributes and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            cap_width_q   <= 2'b00;
            cap_dev_ack_q <= 1'b0;
            dsack_q       <= 2'b00;
            berr_q        <= 1'b0;
            avec_q        <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_n;
            wait_cnt_q    <= wait_cnt_n;
            tmo_cnt_q     <= tmo_cnt_n;
            cap_width_q   <= cap_width_n;
            cap_dev_ack_q <= cap_dev_ack_n;
            dsack_q       <= dsack_n;
            berr_q        <= berr_n;
            avec_q        <= avec_n;
            active_q      <= active_n;
        end
    end

    assign bus.dsack        = dsack_q;
    assign bus.berr         = berr_q;
    assign bus.avec         = avec_q;
    assign bus.cycle_active = active_q;

endmodule

// File: tb/tb_bus_cycle_responder.sv
// Scoreboard bench for bus_cycle_responder at WAIT_STATES=2, BERR_TIMEOUT=16.
module tb_bus_cycle_responder;

    logic clock;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_cycle_responder_if bus ();

    bus_cycle_responder #(
        .WAIT_STATES  (2),
        .BERR_TIMEOUT (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] dsack;
        logic       berr;
        logic       avec;
        int         latency;   // edges counted from the start edge inclusive: N+k -> k+1
    } exp_t;

    exp_t sb_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // At most one termination output may be asserted at any time.
    always @(negedge clock) begin
        n_cmp++;
        if ((int'(bus.dsack != 2'b00) + int'(bus.berr) + int'(bus.avec)) > 1) begin
            n_err++;
            $display("FAIL exclusive: got dsack=%b berr=%b avec=%b expected at most one set",
                     bus.dsack, bus.berr, bus.avec);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.as             = 1'b0;
        bus.port_width     = 2'b00;
        bus.device_null    = 1'b0;
        bus.int_ack        = 1'b0;
        bus.use_device_ack = 1'b0;
        bus.device_ack     = 1'b0;
    endtask

    task automatic start_cycle(input logic [1:0] w, input logic nul, input logic ia, input logic uda);
        bus.port_width     = w;
        bus.device_null    = nul;
        bus.int_ack        = ia;
        bus.use_device_ack = uda;
        bus.device_ack     = 1'b0;
        bus.as             = 1'b1;
    endtask

    // Advance edges until any termination output is seen or the budget runs out.
    task automatic wait_resp(input int budget, output int edges, output logic seen);
        edges = 0;
        seen  = 1'b0;
        while (edges < budget && !seen) begin
            tick();
            edges++;
            if (bus.dsack != 2'b00 || bus.berr || bus.avec) seen = 1'b1;
        end
    endtask

    task automatic end_cycle();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        #3;
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec, bus.cycle_active} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.dsack, bus.berr, bus.avec, bus.cycle_active});
        end
        tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_word_dsack();
        int   e;
        logic s;
        exp_t x;
        start_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        sb_q.push_back('{"word", 2'b10, 1'b0, 1'b0, 4});
        wait_resp(40, e, s);
        x = sb_q.pop_front();
        n_cmp++;
        if (!s || e != x.latency) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e, s, x.latency);
        end
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
            n_err++;
            $display("FAIL %s_outputs: got %b expected %b", x.name,
                     {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
        end
        repeat (3) tick();
        n_cmp++;
        if (bus.dsack !== 2'b10 || bus.cycle_active !== 1'b1) begin
            n_err++;
            $display("FAIL word_hold: got dsack=%b active=%b expected dsack=10 active=1",
                     bus.dsack, bus.cycle_active);
        end
        bus.as = 1'b0;
        tick();
        n_cmp++;
        if (bus.dsack !== 2'b00 || bus.cycle_active !== 1'b0) begin
            n_err++;
            $display("FAIL word_release: got dsack=%b active=%b expected dsack=00 active=0",
                     bus.dsack, bus.cycle_active);
        end
        end_cycle();
    endtask

    task automatic test_device_ack();
        int   e1, e2;
        logic s1, s2;
        exp_t x;
        start_cycle(2'b01, 1'b0, 1'b0, 1'b1);
        sb_q.push_back('{"devack", 2'b01, 1'b0, 1'b0, 8});
        wait_resp(7, e1, s1);
        n_cmp++;
        if (s1 !== 1'b0) begin
            n_err++;
            $display("FAIL devack_early: got response after %0d edges expected none before ack", e1);
        end
        bus.device_ack = 1'b1;
        wait_resp(20, e2, s2);
        x = sb_q.pop_front();
        n_cmp++;
        if (!s2 || (e1 + e2) != x.latency) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e1 + e2, s2, x.latency);
        end
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
            n_err++;
            $display("FAIL %s_outputs: got %b expected %b", x.name,
                     {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
        end
        end_cycle();
    endtask

    task automatic test_timeout();
        int   e;
        logic s;
        exp_t x;
        start_cycle(2'b11, 1'b0, 1'b0, 1'b1);
        sb_q.push_back('{"timeout", 2'b00, 1'b1, 1'b0, 17});
        wait_resp(40, e, s);
        x = sb_q.pop_front();
        n_cmp++;
        if (!s || e != x.latency) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e, s, x.latency);
        end
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
            n_err++;
            $display("FAIL %s_outputs: got %b expected %b", x.name,
                     {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
        end
        // A late device ack in HOLD must not change the outcome.
        bus.device_ack = 1'b1;
        tick();
        n_cmp++;
        if (bus.berr !== 1'b1 || bus.dsack !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_hold: got dsack=%b berr=%b expected 00/1", bus.dsack, bus.berr);
        end
        end_cycle();
    endtask

    task automatic test_ack_at_timeout();
        int   e1, e2;
        logic s1, s2;
        exp_t x;
        start_cycle(2'b11, 1'b0, 1'b0, 1'b1);
        sb_q.push_back('{"ack_vs_timeout", 2'b11, 1'b0, 1'b0, 17});
        wait_resp(16, e1, s1);
        bus.device_ack = 1'b1;
        wait_resp(5, e2, s2);
        x = sb_q.pop_front();
        n_cmp++;
        if (s1 || !s2 || (e1 + e2) != x.latency) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (early=%b seen=%b) expected %0d",
                     x.name, e1 + e2, s1, s2, x.latency);
        end
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
            n_err++;
            $display("FAIL %s_outputs: got %b expected %b", x.name,
                     {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
        end
        end_cycle();
    endtask

    task automatic test_immediate();
        int   e;
        logic s;
        exp_t x;
        logic [1:0] w_tab[3]  = '{2'b10, 2'b00, 2'b11};
        logic       n_tab[3]  = '{1'b1, 1'b0, 1'b0};
        logic       ia_tab[3] = '{1'b0, 1'b0, 1'b1};
        sb_q.push_back('{"null_dev",  2'b00, 1'b1, 1'b0, 1});
        sb_q.push_back('{"null_size", 2'b00, 1'b1, 1'b0, 1});
        sb_q.push_back('{"int_ack",   2'b00, 1'b0, 1'b1, 1});
        for (int i = 0; i < 3; i++) begin
            start_cycle(w_tab[i], n_tab[i], ia_tab[i], 1'b0);
            wait_resp(20, e, s);
            x = sb_q.pop_front();
            n_cmp++;
            if (!s || e != x.latency) begin
                n_err++;
                $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e, s, x.latency);
            end
            n_cmp++;
            if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
                n_err++;
                $display("FAIL %s_outputs: got %b expected %b", x.name,
                         {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
            end
            end_cycle();
        end
    endtask

    task automatic test_abort();
        int   e;
        logic s;
        start_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.cycle_active !== 1'b1) begin
            n_err++;
            $display("FAIL abort_active: got %b expected 1", bus.cycle_active);
        end
        bus.as = 1'b0;
        tick();
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec, bus.cycle_active} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_idle: got %b expected 00000",
                     {bus.dsack, bus.berr, bus.avec, bus.cycle_active});
        end
        wait_resp(6, e, s);
        n_cmp++;
        if (s !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pulse: got response after %0d edges expected none", e);
        end
        end_cycle();
    endtask

    task automatic test_reset_in_hold();
        int   e;
        logic s;
        exp_t x;
        start_cycle(2'b10, 1'b0, 1'b0, 1'b0);
        wait_resp(20, e, s);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.dsack !== 2'b00 || bus.cycle_active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got dsack=%b active=%b expected 00/0", bus.dsack, bus.cycle_active);
        end
        #1 reset_n = 1'b1;
        sb_q.push_back('{"restart", 2'b10, 1'b0, 1'b0, 4});
        wait_resp(20, e, s);
        x = sb_q.pop_front();
        n_cmp++;
        if (!s || e != x.latency) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e, s, x.latency);
        end
        n_cmp++;
        if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
            n_err++;
            $display("FAIL %s_outputs: got %b expected %b", x.name,
                     {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
        end
        end_cycle();
    endtask

    task automatic test_back_to_back();
        int   e;
        logic s;
        exp_t x;
        logic [1:0] w_tab[2] = '{2'b11, 2'b01};
        sb_q.push_back('{"b2b_long", 2'b11, 1'b0, 1'b0, 4});
        sb_q.push_back('{"b2b_byte", 2'b01, 1'b0, 1'b0, 4});
        for (int i = 0; i < 2; i++) begin
            start_cycle(w_tab[i], 1'b0, 1'b0, 1'b0);
            wait_resp(20, e, s);
            x = sb_q.pop_front();
            n_cmp++;
            if (!s || e != x.latency) begin
                n_err++;
                $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", x.name, e, s, x.latency);
            end
            n_cmp++;
            if ({bus.dsack, bus.berr, bus.avec} !== {x.dsack, x.berr, x.avec}) begin
                n_err++;
                $display("FAIL %s_outputs: got %b expected %b", x.name,
                         {bus.dsack, bus.berr, bus.avec}, {x.dsack, x.berr, x.avec});
            end
            // Single idle edge between cycles.
            bus.as = 1'b0;
            tick();
        end
        end_cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_word_dsack();
        test_device_ack();
        test_timeout();
        test_ack_at_timeout();
        test_immediate();
        test_abort();
        test_reset_in_hold();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
